// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Contents: XLEN default, NOP_INSTR (addi x0,x0,0), PC_STEP, fetch_entry_t.
package pc_fetch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ILEN      = 32;
    localparam int unsigned PC_STEP   = 4;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction together with the PC it was read from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_unit_fetch_queue.sv
// Two-entry FIFO decoupling instruction fetch from decode stalls.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   i_push/i_data  write one entry
//   i_pop          retire the head entry
//   i_flush        drop all entries (wins over push/pop)
//   o_count        occupancy 0..2
//   o_head         head entry (stale data when o_count==0)
module fetch_queue #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [DW-1:0] i_data,
    output logic [1:0]    o_count,
    output logic [DW-1:0] o_head
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    // A push while full is only legal when the head leaves in the same cycle
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, same-cycle imem read, and a
// 2-entry {pc, instr} queue toward IF/ID with a valid/ready handshake.
// EX redirects flush the queue and restart fetch at the target.
// Optional feature macro: PC_MISALIGN_TRAP_EN (sticky misaligned-redirect
// trap that halts fetch until reset). Without it, target bits [1:0] are
// cleared and misalign_err is tied low.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   imem_addr/req/rdata      instruction memory fetch
//   redirect_valid/pc        taken branch/jump from EX
//   out_valid/ready/pc/instr queue head toward IF/ID
//   misalign_err             sticky trap flag
module pc_fetch_unit #(
    parameter int unsigned           XLEN     = pc_fetch_pkg::XLEN,
    parameter logic [XLEN-1:0]       RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            misalign_err
);
    import pc_fetch_pkg::*;

    localparam int unsigned EW = XLEN + 32;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_target;
    logic            w_pc_load;
    logic            w_halted;
    logic            w_fetch;
    logic            w_pop;
    logic            w_empty;
    logic [1:0]      w_count;
    logic [EW-1:0]   w_head;

`ifdef PC_MISALIGN_TRAP_EN
    logic r_halted;
    logic r_misalign_err;
    logic w_misaligned;

    // Once halted, redirects are ignored; a misaligned target traps instead of loading
    assign w_misaligned = redirect_valid && !r_halted && (redirect_pc[1:0] != 2'b00);
    assign w_pc_load    = redirect_valid && !r_halted && !w_misaligned;
    assign w_target     = redirect_pc;
    assign w_halted     = r_halted;
    assign misalign_err = r_misalign_err;

    // Sticky trap state, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted       <= 1'b0;
            r_misalign_err <= 1'b0;
        end else if (w_misaligned) begin
            r_halted       <= 1'b1;
            r_misalign_err <= 1'b1;
        end
    end
`else
    logic w_unused_rpc_lsb;

    // Targets are word-aligned by construction
    assign w_pc_load        = redirect_valid;
    assign w_target         = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_rpc_lsb = ^redirect_pc[1:0];
    assign w_halted         = 1'b0;
    assign misalign_err     = 1'b0;
`endif

    // Handshake: a redirect hides the head and blocks both pop and fetch
    assign w_empty   = (w_count == 2'd0);
    assign out_valid = !w_empty && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    assign w_fetch   = !redirect_valid && !w_halted && ((w_count != 2'd2) || w_pop);

    // Flops are held in reset, so only the visible request needs the reset gate
    assign imem_req  = w_fetch && rst;
    assign imem_addr = r_pc;

    assign out_pc    = w_empty ? '0        : w_head[EW-1 -: XLEN];
    assign out_instr = w_empty ? NOP_INSTR : w_head[31:0];

    // Program counter: redirect beats sequential advance; wraps modulo 2^XLEN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= w_target;
        end else if (w_fetch) begin
            r_pc <= r_pc + XLEN'(PC_STEP);
        end
    end

    fetch_queue #(
        .DW (EW)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({r_pc, imem_rdata}),
        .o_count (w_count),
        .o_head  (w_head)
    );

endmodule
